resampler_sched: RTL and testbench
==================================

RESAMPLER_SCHED -- requirements
Module: resampler_sched

Interface
REQ-001 The module SHALL have the parameter NUM_CH, default 8, giving the number of audio channels.
REQ-002 The module SHALL have the parameter NUM_CH_LOG2, default 3, giving the channel index width.
REQ-003 The module SHALL have the parameter NUM_FIR, default 160, giving the number of polyphase subfilters.
REQ-004 The module SHALL have the parameter NUM_FIR_LOG2, default 8, giving the subfilter index width.
REQ-005 The module SHALL have the parameter DECIM, default 147, giving the phase step per output sample; legal range is 1..NUM_FIR.
REQ-006 The module SHALL have the parameter WDOG_CYCLES, default 512, giving the watchdog limit (REQ-027).
REQ-007 The module SHALL have the parameter WDOG_LOG2, default 10, giving the watchdog counter width.
REQ-008 The module SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 The module SHALL have the port req_i, input, NUM_CH bits: per-channel output-sample request pulses.
REQ-011 The module SHALL have the port ack_o, output, NUM_CH bits: one-hot, one-cycle completion pulse for the serviced channel.
REQ-012 The module SHALL have the port start_o, output, 1 bit: one-cycle pulse that launches the MAC datapath.
REQ-013 The module SHALL have the port ch_o, output, NUM_CH_LOG2 bits: channel being processed.
REQ-014 The module SHALL have the port rwing_firidx_o, output, NUM_FIR_LOG2 bits: right-wing subfilter index.
REQ-015 The module SHALL have the port lwing_firidx_o, output, NUM_FIR_LOG2 bits: left-wing subfilter index, NUM_FIR-1-rwing_firidx_o.
REQ-016 The module SHALL have the port done_i, input, 1 bit: one-cycle pulse from the datapath marking computation complete.
REQ-017 The module SHALL have the port ringbuf_pop_o, output, NUM_CH bits: one-hot, one-cycle pulse that pops one input sample from the channel ring buffer.
REQ-018 The module SHALL have the port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-019 The module SHALL have the port err_o, output, 1 bit: sticky watchdog error flag.

Function
REQ-020 The module SHALL hold a pending bit per channel; a req_i bit high at a clock edge sets the matching pending bit.
REQ-021 The pending bit SHALL be cleared in the UPDATE cycle of the serviced channel; a req_i on that channel in the same cycle SHALL win, leaving the bit set.
REQ-022 The FSM SHALL have the four states IDLE, ISSUE, WAIT and UPDATE.
REQ-023 IDLE SHALL move to ISSUE when any pending bit is set; it SHALL register the granted channel by round-robin, searching from (last granted+1) mod NUM_CH.
REQ-024 ISSUE SHALL last 1 cycle, with start_o=1 and ch_o, rwing_firidx_o and lwing_firidx_o valid; those outputs SHALL hold until the FSM returns to IDLE.
REQ-025 WAIT SHALL sample done_i and move to UPDATE on done_i=1; done_i is ignored in every other state.
REQ-026 UPDATE SHALL last 1 cycle and pulse ack_o[ch]; it SHALL write the new phase with sum = phase[ch]+DECIM, computed NUM_FIR_LOG2+1 bits wide.
- If sum >= NUM_FIR: phase[ch] = sum-NUM_FIR, and ringbuf_pop_o[ch] pulses in the same cycle.
- Otherwise: phase[ch] = sum, and there is no pop.
- UPDATE then returns to IDLE.
REQ-027 Latency SHALL be as follows.
- A req_i pulse in cycle t with the FSM idle gives start_o in cycle t+2.
- done_i in cycle d gives ack_o in cycle d+1.
- The minimum request-to-request turnaround on one channel is 4 cycles plus the datapath time.
REQ-028 rwing_firidx_o SHALL equal phase[ch] as it stood before the UPDATE write.
REQ-029 A req_i for a channel already pending SHALL be absorbed and produce no second ack.

Reset
REQ-030 With rst=1, on the next edge the FSM SHALL enter IDLE and clear the following to 0: all pending bits, all phases, ack_o, start_o, ringbuf_pop_o, busy_o, err_o, ch_o, rwing_firidx_o and the last-granted pointer; lwing_firidx_o SHALL read NUM_FIR-1.
REQ-031 A reset asserted mid-operation (ISSUE, WAIT or UPDATE) SHALL abort the operation with no ack_o or pop pulse in the reset cycle or after it.

Configuration
REQ-032 With the macro RESAMPLER_SCHED_WATCHDOG_EN defined, a counter SHALL run in WAIT. If it reaches WDOG_CYCLES-1 without done_i, the FSM SHALL go to UPDATE with:
- ack_o[ch] pulsed;
- phase[ch] unchanged;
- no ringbuf_pop_o;
- err_o set, staying set until rst.
REQ-033 Without RESAMPLER_SCHED_WATCHDOG_EN, the watchdog counter SHALL not exist, WAIT SHALL wait indefinitely, and err_o SHALL be tied to 0.

Verification
REQ-034 Scenario: after reset, req_i=8'h04 for 1 cycle, done_i 10 cycles after start_o -> start_o 2 cycles after the request with ch_o=2, rwing_firidx_o=0 and lwing_firidx_o=159; ack_o=8'h04 one cycle after done_i; no pop; phase[2]=147.
REQ-035 Scenario: a second request on channel 2 -> rwing_firidx_o=147 and lwing_firidx_o=12; at UPDATE, ringbuf_pop_o=8'h04 and phase[2]=134.
REQ-036 Scenario: req_i=8'hFF in one cycle -> service order 0,1,...,7 with exactly eight acks; after channel 7, a req_i=8'h81 -> service order 0 then 7.
REQ-037 Scenario: req_i[3] re-pulsed in the UPDATE cycle of channel 3 -> channel 3 is serviced again without another request.
REQ-038 Scenario: rst asserted during WAIT -> busy_o=0 next cycle; no ack_o ever for the aborted channel; all phases read 0 on the next service.
REQ-039 Scenario with the watchdog macro enabled and done_i withheld -> ack_o fires after WDOG_CYCLES cycles in WAIT, err_o=1, phase unchanged; without the macro, busy_o stays 1 and err_o=0.

Source files
------------

// File: rtl/resampler_sched.sv
// resampler_sched: round-robin channel scheduler for a polyphase resampler MAC datapath; optional WAIT watchdog under RESAMPLER_SCHED_WATCHDOG_EN
module resampler_sched #(
    parameter int NUM_CH       = 8,
    parameter int NUM_CH_LOG2  = 3,
    parameter int NUM_FIR      = 160,
    parameter int NUM_FIR_LOG2 = 8,
    parameter int DECIM        = 147,
    parameter int WDOG_CYCLES  = 512,
    parameter int WDOG_LOG2    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req_i,
    output logic [NUM_CH-1:0]       ack_o,
    output logic                    start_o,
    output logic [NUM_CH_LOG2-1:0]  ch_o,
    output logic [NUM_FIR_LOG2-1:0] rwing_firidx_o,
    output logic [NUM_FIR_LOG2-1:0] lwing_firidx_o,
    input  logic                    done_i,
    output logic [NUM_CH-1:0]       ringbuf_pop_o,
    output logic                    busy_o,
    output logic                    err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;
    state_t                  r_state;
    logic [NUM_CH-1:0]       r_pend, r_ack, r_pop, w_onehot;
    logic [NUM_CH_LOG2-1:0]  r_ch, w_grant;
    logic [NUM_CH_LOG2:0]    w_idx;
    logic [NUM_FIR_LOG2-1:0] r_phase [NUM_CH];
    logic [NUM_FIR_LOG2-1:0] r_rwing, r_lwing, w_next;
    logic [NUM_FIR_LOG2:0]   w_sum;
    logic                    r_start, w_wrap, w_tout;

    assign w_onehot = NUM_CH'(1) << r_ch;
    assign w_sum    = {1'b0, r_rwing} + (NUM_FIR_LOG2+1)'(DECIM);
    assign w_wrap   = w_sum >= (NUM_FIR_LOG2+1)'(NUM_FIR);
    assign w_next   = w_wrap ? NUM_FIR_LOG2'(w_sum - (NUM_FIR_LOG2+1)'(NUM_FIR)) : w_sum[NUM_FIR_LOG2-1:0];

    // round-robin pick: scan offsets high to low so the nearest pending channel after r_ch wins
    always_comb begin
        w_grant = r_ch;
        w_idx   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = {1'b0, r_ch} + (NUM_CH_LOG2+1)'(k);
            w_idx = (w_idx >= (NUM_CH_LOG2+1)'(NUM_CH)) ? w_idx - (NUM_CH_LOG2+1)'(NUM_CH) : w_idx;
            w_grant = r_pend[w_idx[NUM_CH_LOG2-1:0]] ? w_idx[NUM_CH_LOG2-1:0] : w_grant;
        end
    end

    // scheduler FSM; phase write and pop are issued on entry to UPDATE so they appear with ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_ack   <= '0;
            r_pop   <= '0;
            r_start <= 1'b0;
            r_ch    <= '0;
            r_rwing <= '0;
            r_lwing <= NUM_FIR_LOG2'(NUM_FIR - 1);
            for (int i = 0; i < NUM_CH; i++) r_phase[i] <= '0;
        end else begin
            r_pend  <= (r_pend & ~({NUM_CH{r_state == UPDATE}} & w_onehot)) | req_i;
            r_ack   <= '0;
            r_pop   <= '0;
            r_start <= 1'b0;
            case (r_state)
                IDLE: if (|r_pend) begin
                    r_state <= ISSUE;
                    r_start <= 1'b1;
                    r_ch    <= w_grant;
                    r_rwing <= r_phase[w_grant];
                    r_lwing <= NUM_FIR_LOG2'(NUM_FIR - 1) - r_phase[w_grant];
                end
                ISSUE: r_state <= WAIT;
                WAIT: if (done_i || w_tout) begin
                    r_state <= UPDATE;
                    r_ack   <= w_onehot;
                    if (done_i) begin
                        r_phase[r_ch] <= w_next;
                        r_pop         <= w_wrap ? w_onehot : '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_o        = r_start;
    assign ch_o           = r_ch;
    assign rwing_firidx_o = r_rwing;
    assign lwing_firidx_o = r_lwing;
    assign busy_o         = r_state != IDLE;
    assign ack_o          = rst ? '0 : r_ack;
    assign ringbuf_pop_o  = rst ? '0 : r_pop;

`ifdef RESAMPLER_SCHED_WATCHDOG_EN
    logic [WDOG_LOG2-1:0] r_wdog;
    logic                 r_err;
    assign w_tout = r_wdog == WDOG_LOG2'(WDOG_CYCLES - 1);
    // count consecutive WAIT cycles; a timeout without done latches the error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= (r_state == WAIT) ? r_wdog + 1'b1 : '0;
            r_err  <= r_err | (r_state == WAIT && w_tout && !done_i);
        end
    end
    assign err_o = r_err;
`else
    assign w_tout = 1'b0;
    assign err_o  = 1'b0;
`endif
endmodule

// File: tb/tb_resampler_sched.sv
// tb_resampler_sched: scoreboard bench for resampler_sched (default and RESAMPLER_SCHED_WATCHDOG_EN builds)
module tb_resampler_sched;
    localparam int NFIR = 160;
    localparam int DEC  = 147;
    localparam int WDOG = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done_i = 1'b0;
    logic [7:0] req_i = '0;
    logic [7:0] ack_o, pop_o;
    logic       start_o, busy_o, err_o;
    logic [2:0] ch_o;
    logic [7:0] rwing_o, lwing_o;

    int n_chk = 0;
    int n_err = 0;
    int q_ch[$];
    int ph[8];

    resampler_sched dut (
        .clk(clk), .rst(rst), .req_i(req_i), .ack_o(ack_o), .start_o(start_o),
        .ch_o(ch_o), .rwing_firidx_o(rwing_o), .lwing_firidx_o(lwing_o), .done_i(done_i),
        .ringbuf_pop_o(pop_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req_pulse(input logic [7:0] m);
        req_i = m;
        @(negedge clk);
        req_i = '0;
    endtask

    task automatic wait_start(output int cnt);
        cnt = 0;
        while (!start_o && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("start_seen", start_o, 1);
    endtask

    task automatic serve(input int dly, input int exp_lat, input logic [7:0] rereq);
        int cnt, c, s;
        logic [7:0] oh;
        wait_start(cnt);
        if (!start_o) return;
        if (exp_lat >= 0) check("start_latency", cnt, exp_lat);
        check("sb_nonempty", q_ch.size() > 0, 1);
        if (q_ch.size() == 0) return;
        c  = q_ch.pop_front();
        oh = 8'(1) << c;
        check("ch_o", ch_o, c);
        check("rwing", rwing_o, ph[c]);
        check("lwing", lwing_o, NFIR - 1 - ph[c]);
        check("busy_issue", busy_o, 1);
        @(negedge clk);
        check("start_len", start_o, 0);
        repeat (dly - 1) @(negedge clk);
        check("no_early_ack", ack_o, 0);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        req_i  = rereq;
        s = ph[c] + DEC;
        check("ack", ack_o, oh);
        check("pop", pop_o, s >= NFIR ? oh : 8'h00);
        check("ch_hold", ch_o, c);
        ph[c] = s >= NFIR ? s - NFIR : s;
        @(negedge clk);
        req_i = '0;
        check("ack_len", ack_o, 0);
        check("pop_len", pop_o, 0);
    endtask

    task automatic quiet(input int n, input string tag);
        int s = 0;
        repeat (n) begin
            @(negedge clk);
            s += int'(start_o) + int'(|ack_o) + int'(|pop_o);
        end
        check(tag, s, 0);
    endtask

    initial begin
        int cnt;
        int acks;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_start", start_o, 0);
        check("rst_ack", ack_o, 0);
        check("rst_pop", pop_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ch", ch_o, 0);
        check("rst_rwing", rwing_o, 0);
        check("rst_lwing", lwing_o, NFIR - 1);
        rst = 1'b0;
        @(negedge clk);

        q_ch.push_back(2); req_pulse(8'h04); serve(10, 1, 8'h00);
        q_ch.push_back(2); req_pulse(8'h04); serve(5, 1, 8'h00);
        q_ch.push_back(2); req_pulse(8'h04); serve(3, 1, 8'h00);

        q_ch.push_back(7); req_pulse(8'h80); serve(2, -1, 8'h00);
        for (int i = 0; i < 8; i++) q_ch.push_back(i);
        req_pulse(8'hFF);
        req_pulse(8'hFF);
        for (int i = 0; i < 8; i++) serve(1 + i, -1, 8'h00);
        quiet(20, "ff_no_extra");
        q_ch.push_back(0); q_ch.push_back(7);
        req_pulse(8'h81);
        serve(2, -1, 8'h00);
        serve(3, -1, 8'h00);
        quiet(20, "rr81_no_extra");

        q_ch.push_back(3); q_ch.push_back(3);
        req_pulse(8'h08);
        serve(4, -1, 8'h08);
        serve(4, -1, 8'h00);
        quiet(20, "rereq_no_extra");

        req_pulse(8'h20);
        wait_start(cnt);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("abort_ack_rst_cycle", ack_o, 0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy_o, 0);
        for (int i = 0; i < 8; i++) ph[i] = 0;
        quiet(30, "abort_quiet");
        q_ch.push_back(2); req_pulse(8'h04); serve(2, 1, 8'h00);
        q_ch.push_back(7); req_pulse(8'h80); serve(2, 1, 8'h00);

        req_pulse(8'h02);
        wait_start(cnt);
        acks = 0;
`ifdef RESAMPLER_SCHED_WATCHDOG_EN
        cnt = 0;
        while (ack_o == 0 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("wd_ack_cycle", cnt, WDOG + 1);
        check("wd_ack", ack_o, 8'h02);
        check("wd_pop", pop_o, 0);
        @(negedge clk);
        check("wd_err", err_o, 1);
        check("wd_idle", busy_o, 0);
        q_ch.push_back(1); req_pulse(8'h02); serve(2, 1, 8'h00);
        check("wd_err_sticky", err_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wd_err_cleared", err_o, 0);
`else
        repeat (WDOG + 100) begin
            @(negedge clk);
            acks += int'(|ack_o);
        end
        check("nowd_acks", acks, 0);
        check("nowd_busy", busy_o, 1);
        check("nowd_err", err_o, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("nowd_reset_busy", busy_o, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
